// File: rtl/regfile_pkg.sv
// Shared constants and configuration helpers for the multi-port register file.
package regfile_pkg;

    // Default data width of one architectural register.
    localparam int XLEN_DEF  = 32;
    // Default number of architectural registers.
    localparam int NREGS_DEF = 32;

    // Address width needed to index nregs registers.
    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

    // Legal configurations: NREGS is a power of two in 2..64 and ZERO_REG is 0 or 1.
    function automatic bit cfg_ok(input int nregs, input int zero_reg);
        return (nregs >= 2) && (nregs <= 64) && ((nregs & (nregs - 1)) == 0) &&
               ((zero_reg == 0) || (zero_reg == 1));
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
// There is no valid/ready handshake on this bus. Reads are purely combinational.
// The rsN_ready flags report operand availability; they are not flow control.
// A write or issue takes effect on the rising edge where its enable is high.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
);
    localparam int AW = addr_width(NREGS);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_ready;
    logic            rs2_ready;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [XLEN-1:0] wa_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [NREGS-1:0] pending;

    modport master (
        output rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data, iss_en, iss_rd, dbg_addr,
        input  rs1_data, rs2_data, rs1_ready, rs2_ready, dbg_data, pending
    );

    modport slave (
        input  rs1_addr, rs2_addr, wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data, iss_en, iss_rd, dbg_addr,
        output rs1_data, rs2_data, rs1_ready, rs2_ready, dbg_data, pending
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, set wins over clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_iss_en,
    input  logic [AW-1:0]    i_iss_rd,
    input  logic             i_wa_en,
    input  logic [AW-1:0]    i_wa_addr,
    input  logic             i_wb_en,
    input  logic [AW-1:0]    i_wb_addr,
    input  logic [AW-1:0]    i_rs1_addr,
    input  logic [AW-1:0]    i_rs2_addr,
    output logic [NREGS-1:0] o_pending,
    output logic             o_rs1_ready,
    output logic             o_rs2_ready
);

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_pending_nxt;

    // Decode issue and writeback into per-register set/clear masks.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_set[i] = i_iss_en && (i_iss_rd == AW'(i));
            w_clr[i] = (i_wa_en && (i_wa_addr == AW'(i))) ||
                       (i_wb_en && (i_wb_addr == AW'(i)));
        end
        // A new producer issued in the same cycle as a writeback keeps the bit set.
        w_pending_nxt = (r_pending & ~w_clr) | w_set;
        if (ZERO_REG != 0) begin
            w_pending_nxt[0] = 1'b0;
        end
    end

    // Pending state register; reset drops every reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // An operand is ready when not reserved or when its write is on the bus right now.
    always_comb begin
        o_rs1_ready = !r_pending[i_rs1_addr] ||
                      (i_wa_en && (i_wa_addr == i_rs1_addr)) ||
                      (i_wb_en && (i_wb_addr == i_rs1_addr));
        o_rs2_ready = !r_pending[i_rs2_addr] ||
                      (i_wa_en && (i_wa_addr == i_rs2_addr)) ||
                      (i_wb_en && (i_wb_addr == i_rs2_addr));
        if ((ZERO_REG != 0) && (i_rs1_addr == '0)) begin
            o_rs1_ready = 1'b1;
        end
        if ((ZERO_REG != 0) && (i_rs2_addr == '0)) begin
            o_rs2_ready = 1'b1;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two bypassed read ports, two prioritised
// write ports (B beats A), a debug read port and a pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_width(NREGS)
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    if (!cfg_ok(NREGS, ZERO_REG)) begin : g_bad_cfg
        $error("regfile_mp: NREGS must be a power of two in 2..64 and ZERO_REG 0 or 1");
    end

    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wa_we;
    logic            w_wb_we;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_dbg_data;

    // Qualify writes: with ZERO_REG the zero register silently ignores writes.
    always_comb begin
        w_wa_we = bus.wa_en && !((ZERO_REG != 0) && (bus.wa_addr == '0));
        w_wb_we = bus.wb_en && !((ZERO_REG != 0) && (bus.wb_addr == '0));
    end

    // Array update; port B is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wa_we) begin
                r_mem[bus.wa_addr] <= bus.wa_data;
            end
            if (w_wb_we) begin
                r_mem[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    // Read muxes, lowest priority first: array, port A bypass, port B bypass, zero reg.
    always_comb begin
        w_rs1_data = r_mem[bus.rs1_addr];
        if (bus.wa_en && (bus.wa_addr == bus.rs1_addr)) w_rs1_data = bus.wa_data;
        if (bus.wb_en && (bus.wb_addr == bus.rs1_addr)) w_rs1_data = bus.wb_data;
        if ((ZERO_REG != 0) && (bus.rs1_addr == '0))    w_rs1_data = '0;

        w_rs2_data = r_mem[bus.rs2_addr];
        if (bus.wa_en && (bus.wa_addr == bus.rs2_addr)) w_rs2_data = bus.wa_data;
        if (bus.wb_en && (bus.wb_addr == bus.rs2_addr)) w_rs2_data = bus.wb_data;
        if ((ZERO_REG != 0) && (bus.rs2_addr == '0))    w_rs2_data = '0;
    end

    // Debug port shows raw stored contents only, never in-flight write data.
    always_comb begin
        w_dbg_data = r_mem[bus.dbg_addr];
        if ((ZERO_REG != 0) && (bus.dbg_addr == '0)) w_dbg_data = '0;
    end

    assign bus.rs1_data = w_rs1_data;
    assign bus.rs2_data = w_rs2_data;
    assign bus.dbg_data = w_dbg_data;

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_iss_en    (bus.iss_en),
        .i_iss_rd    (bus.iss_rd),
        .i_wa_en     (bus.wa_en),
        .i_wa_addr   (bus.wa_addr),
        .i_wb_en     (bus.wb_en),
        .i_wb_addr   (bus.wb_addr),
        .i_rs1_addr  (bus.rs1_addr),
        .i_rs2_addr  (bus.rs2_addr),
        .o_pending   (bus.pending),
        .o_rs1_ready (bus.rs1_ready),
        .o_rs2_ready (bus.rs2_ready)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default 32x32 instance with x0 hardwired,
// and a 16x64 instance with ZERO_REG=0. Expected values are queued by the driver
// and compared by a monitor on the falling edge.
module tb_regfile_mp;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    // Selectors for the output being checked.
    localparam int A_RS1 = 0, A_RS2 = 1, A_RDY1 = 2, A_RDY2 = 3, A_DBG = 4, A_PEND = 5;
    localparam int B_RS1 = 6, B_RS2 = 7, B_RDY1 = 8, B_DBG = 9, B_PEND = 10;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   checks;
    int   errors;

    regfile_if #(.XLEN(32), .NREGS(32)) bus_a ();
    regfile_if #(.XLEN(64), .NREGS(16)) bus_b ();

    regfile_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .ZERO_REG(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            A_RS1:   return 64'(bus_a.rs1_data);
            A_RS2:   return 64'(bus_a.rs2_data);
            A_RDY1:  return 64'(bus_a.rs1_ready);
            A_RDY2:  return 64'(bus_a.rs2_ready);
            A_DBG:   return 64'(bus_a.dbg_data);
            A_PEND:  return 64'(bus_a.pending);
            B_RS1:   return bus_b.rs1_data;
            B_RS2:   return bus_b.rs2_data;
            B_RDY1:  return 64'(bus_b.rs1_ready);
            B_DBG:   return bus_b.dbg_data;
            B_PEND:  return 64'(bus_b.pending);
            default: return 64'hX;
        endcase
    endfunction

    // Monitor: drain every expectation queued for this cycle and compare.
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = actual(e.sel);
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [63:0] v, input string nm);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Advance to just after the next rising edge and release one-shot controls.
    task automatic step();
        @(posedge clk);
        #1;
        bus_a.wa_en  = 1'b0;
        bus_a.wb_en  = 1'b0;
        bus_a.iss_en = 1'b0;
        bus_b.wa_en  = 1'b0;
        bus_b.wb_en  = 1'b0;
        bus_b.iss_en = 1'b0;
    endtask

    task automatic wr_a(input bit port_b, input logic [4:0] a, input logic [31:0] d);
        if (port_b) begin
            bus_a.wb_en = 1'b1; bus_a.wb_addr = a; bus_a.wb_data = d;
        end else begin
            bus_a.wa_en = 1'b1; bus_a.wa_addr = a; bus_a.wa_data = d;
        end
    endtask

    task automatic iss_a(input logic [4:0] rd);
        bus_a.iss_en = 1'b1;
        bus_a.iss_rd = rd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.rs1_addr = '0; bus_a.rs2_addr = '0; bus_a.dbg_addr = '0;
        bus_a.wa_en = 1'b0; bus_a.wa_addr = '0; bus_a.wa_data = '0;
        bus_a.wb_en = 1'b0; bus_a.wb_addr = '0; bus_a.wb_data = '0;
        bus_a.iss_en = 1'b0; bus_a.iss_rd = '0;
        bus_b.rs1_addr = '0; bus_b.rs2_addr = '0; bus_b.dbg_addr = '0;
        bus_b.wa_en = 1'b0; bus_b.wa_addr = '0; bus_b.wa_data = '0;
        bus_b.wb_en = 1'b0; bus_b.wb_addr = '0; bus_b.wb_data = '0;
        bus_b.iss_en = 1'b0; bus_b.iss_rd = '0;

        // Two reset edges.
        step();
        step();
        rst = 1'b0;

        // Reset state.
        bus_a.rs1_addr = 5'd5; bus_a.rs2_addr = 5'd31; bus_a.dbg_addr = 5'd7;
        expect_val(A_RS1, 64'h0, "rst_rs1");
        expect_val(A_RS2, 64'h0, "rst_rs2");
        expect_val(A_RDY1, 64'h1, "rst_rdy1");
        expect_val(A_RDY2, 64'h1, "rst_rdy2");
        expect_val(A_DBG, 64'h0, "rst_dbg");
        expect_val(A_PEND, 64'h0, "rst_pend");
        expect_val(B_PEND, 64'h0, "rst_pend_b");
        step();

        // Write to x0 is dropped and never bypassed.
        wr_a(0, 5'd0, 32'hDEADBEEF);
        bus_a.rs1_addr = 5'd0;
        expect_val(A_RS1, 64'h0, "x0_bypass");
        step();
        bus_a.dbg_addr = 5'd0;
        expect_val(A_RS1, 64'h0, "x0_rs1");
        expect_val(A_DBG, 64'h0, "x0_dbg");
        expect_val(A_PEND, 64'h0, "x0_pend");
        step();

        // Same-cycle bypass; debug shows old value until the next cycle.
        wr_a(0, 5'd5, 32'h12345678);
        bus_a.rs1_addr = 5'd5; bus_a.dbg_addr = 5'd5;
        expect_val(A_RS1, 64'h12345678, "x5_bypass");
        expect_val(A_DBG, 64'h0, "x5_dbg_old");
        step();
        expect_val(A_DBG, 64'h12345678, "x5_dbg_new");
        expect_val(A_RS1, 64'h12345678, "x5_rs1");
        step();

        // Dual-write collision: port B wins.
        wr_a(0, 5'd7, 32'h1111);
        wr_a(1, 5'd7, 32'h2222);
        bus_a.rs2_addr = 5'd7;
        expect_val(A_RS2, 64'h2222, "coll_bypass");
        step();
        bus_a.dbg_addr = 5'd7;
        expect_val(A_DBG, 64'h2222, "coll_stored");
        expect_val(A_RS2, 64'h2222, "coll_rs2");
        step();

        // Two different addresses in one cycle.
        wr_a(0, 5'd3, 32'hA);
        wr_a(1, 5'd4, 32'hB);
        bus_a.rs1_addr = 5'd3; bus_a.rs2_addr = 5'd4;
        expect_val(A_RS1, 64'hA, "dual_byp_a");
        expect_val(A_RS2, 64'hB, "dual_byp_b");
        step();
        bus_a.rs1_addr = 5'd4; bus_a.rs2_addr = 5'd3; bus_a.dbg_addr = 5'd3;
        expect_val(A_RS1, 64'hB, "dual_x4");
        expect_val(A_RS2, 64'hA, "dual_x3");
        expect_val(A_DBG, 64'hA, "dual_dbg_x3");
        step();

        // Scoreboard: issue x9.
        iss_a(5'd9);
        bus_a.rs1_addr = 5'd9; bus_a.rs2_addr = 5'd0;
        expect_val(A_RDY1, 64'h1, "iss_rdy_before");
        step();
        expect_val(A_RDY1, 64'h0, "iss_rdy_pend");
        expect_val(A_RDY2, 64'h1, "x0_rdy");
        expect_val(A_PEND, 64'h200, "iss_pend");
        step();
        wr_a(1, 5'd9, 32'h55);
        expect_val(A_RDY1, 64'h1, "wb_rdy");
        expect_val(A_RS1, 64'h55, "wb_data");
        expect_val(A_PEND, 64'h200, "wb_pend_same");
        step();
        bus_a.dbg_addr = 5'd9;
        expect_val(A_PEND, 64'h0, "wb_pend_clr");
        expect_val(A_RDY1, 64'h1, "wb_rdy_after");
        expect_val(A_DBG, 64'h55, "wb_dbg");
        step();

        // Set beats clear.
        iss_a(5'd9);
        wr_a(0, 5'd9, 32'h77);
        expect_val(A_RDY1, 64'h1, "sbc_rdy");
        expect_val(A_RS1, 64'h77, "sbc_data");
        step();
        expect_val(A_PEND, 64'h200, "sbc_pend");
        expect_val(A_RDY1, 64'h0, "sbc_rdy_after");
        expect_val(A_RS1, 64'h77, "sbc_stored");
        iss_a(5'd9);
        step();
        expect_val(A_PEND, 64'h200, "reissue_pend");
        iss_a(5'd0);
        step();
        expect_val(A_PEND, 64'h200, "iss_x0_pend");
        wr_a(0, 5'd12, 32'hC);
        step();
        expect_val(A_PEND, 64'h200, "wr_nonpend");

        // Reset with a reservation outstanding; same-cycle write/issue ignored.
        rst = 1'b1;
        wr_a(0, 5'd13, 32'hD);
        iss_a(5'd14);
        step();
        rst = 1'b0;
        bus_a.rs1_addr = 5'd9; bus_a.dbg_addr = 5'd9; bus_a.rs2_addr = 5'd13;
        expect_val(A_PEND, 64'h0, "rst2_pend");
        expect_val(A_DBG, 64'h0, "rst2_x9");
        expect_val(A_RS1, 64'h0, "rst2_rs1");
        expect_val(A_RDY1, 64'h1, "rst2_rdy1");
        expect_val(A_RS2, 64'h0, "rst2_x13");
        step();

        // ZERO_REG=0 instance: x0 writable and reservable.
        bus_b.wa_en = 1'b1; bus_b.wa_addr = 4'd0; bus_b.wa_data = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_b.rs1_addr = 4'd0;
        expect_val(B_RS1, 64'hFFFF_FFFF_FFFF_FFFF, "b_x0_bypass");
        step();
        bus_b.dbg_addr = 4'd0;
        bus_b.iss_en = 1'b1; bus_b.iss_rd = 4'd0;
        expect_val(B_DBG, 64'hFFFF_FFFF_FFFF_FFFF, "b_x0_dbg");
        expect_val(B_RS1, 64'hFFFF_FFFF_FFFF_FFFF, "b_x0_rs1");
        step();
        bus_b.wb_en = 1'b1; bus_b.wb_addr = 4'd15; bus_b.wb_data = 64'h0123_4567_89AB_CDEF;
        bus_b.rs2_addr = 4'd15;
        expect_val(B_PEND, 64'h1, "b_pend0");
        expect_val(B_RDY1, 64'h0, "b_rdy0");
        expect_val(B_RS2, 64'h0123_4567_89AB_CDEF, "b_x15_bypass");
        step();
        bus_b.dbg_addr = 4'd15;
        expect_val(B_DBG, 64'h0123_4567_89AB_CDEF, "b_x15_dbg");
        step();
        step();

        // Every queued expectation must have been consumed.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next-generation core; it replaces the single-write 32x32 file.
- Provides two combinational read ports with same-cycle write bypass and two write ports with fixed priority.
- Contains a per-register pending scoreboard that the issue stage sets and writeback clears, plus a debug read port for the board display.
- Sits between decode/issue, which reads and reserves registers, and the EX and MEM writeback paths.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, number of architectural registers. Must be a power of two, 2..64.
- AW, $clog2(NREGS), address width. Derived; never overridden.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero, is never written and is never pending.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational, bypassed).
- rs2_data  out  XLEN  read port 2 data (combinational, bypassed).
- rs1_ready  out  1  operand 1 is valid: not pending, or being written this cycle.
- rs2_ready  out  1  operand 2 is valid: not pending, or being written this cycle.
- wa_en  in  1  write port A enable (EX writeback).
- wa_addr  in  AW  write port A address.
- wa_data  in  XLEN  write port A data.
- wb_en  in  1  write port B enable (MEM writeback; higher priority).
- wb_addr  in  AW  write port B address.
- wb_data  in  XLEN  write port B data.
- iss_en  in  1  issue reserves a destination register.
- iss_rd  in  AW  destination register to mark pending.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  raw array contents at dbg_addr; no bypass.
- pending  out  NREGS  scoreboard vector; bit i set means register i is awaiting a write.

Behaviour:
- Reset (rst=1 at a clock edge): all registers are cleared to 0 and pending is cleared to 0. Writes and issue in the same cycle are ignored. Reset overrides an operation in progress; a reservation cleared by reset is not restored.
- Reset values of outputs: they are combinational from cleared state, so every data output reads 0, pending reads 0 and both ready outputs read 1.
- Write: on a rising edge, if wX_en=1 and the address is not the zero register (when ZERO_REG=1), the array is updated.
  - Both ports enabled to the same address: port B data is stored; port A is dropped.
  - Different addresses: both are stored in the same cycle.
- Read timing: combinational, zero latency.
  - Priority: zero register (ZERO_REG=1) returns 0; otherwise port B write data if wb_en and wb_addr match; otherwise port A write data if wa_en and wa_addr match; otherwise array contents.
  - Array contents reflect a write from the next cycle onward.
- Scoreboard, per register i, on a rising edge:
  - Set: iss_en and iss_rd==i.
  - Clear: (wa_en and wa_addr==i) or (wb_en and wb_addr==i).
  - Set and clear in the same cycle: set wins, so pending ends at 1 (a new producer has been issued).
  - Register 0 is never set when ZERO_REG=1.
  - Re-issuing an already-pending register keeps it at 1.
  - A write to a non-pending register is legal and leaves pending at 0.
- Ready: rsN_ready = !pending[rsN_addr] OR (a matching write is enabled this cycle). For the zero register, ready is always 1.
- Debug port: dbg_data is array contents only. It is 0 for the zero register and is not affected by bypass.
- Width rules: no arithmetic is performed on data. Addresses are unsigned; with NREGS a power of two there are no out-of-range addresses.

Decomposition:
- Package regfile_pkg holds the XLEN default, the AW computation and a function that checks the ZERO_REG/NREGS legality; the legality check is used in an elaboration assertion.
- One sub-module, regfile_scoreboard, holds the NREGS pending bits, implements the set/clear priority and produces the ready terms. It takes the iss, wa and wb signals and the two read addresses.
- The array, write priority and bypass muxes stay in regfile_mp.

Test Plan:
- Reset and zero register: assert rst for 2 cycles, then write 0xDEADBEEF to x0 via port A → rs1_data=0, dbg_data(x0)=0, pending=0 in the following cycle.
- Write/bypass: wa writes 0x12345678 to x5 while rs1_addr=5 in the same cycle → rs1_data=0x12345678 in that cycle; dbg_data(x5) is the old value 0 until the next cycle, then 0x12345678.
- Dual-write collision: wa x7=0x1111 and wb x7=0x2222 in one cycle → rs2_data (rs2_addr=7) = 0x2222 in that cycle and the stored value is 0x2222. Separately, wa x3=0xA and wb x4=0xB → both stored.
- Scoreboard: issue x9, then the next cycle rs1_addr=9 → rs1_ready=0, pending[9]=1. When wb writes x9=0x55, rs1_ready=1 and rs1_data=0x55 in that cycle, and pending[9]=0 from the next cycle.
- Set-beats-clear: in the same cycle, iss x9 and wa writes x9 → pending[9]=1 after the edge. Reset asserted with pending[9]=1 → pending=0 and x9=0 on the next edge.
- Parameter sweep: NREGS=16, XLEN=64, ZERO_REG=0 → x0 is writable (0xFFFF_FFFF_FFFF_FFFF reads back), AW=4, and pending[0] can be set.
